// File: rtl/ula_core_if.sv
// Operand/opcode/result bundle for the REDUX-V ALU.
// The master drives operands; the slave returns result and flags.
interface ula_core_if #(
    parameter int BITS   = 8,
    parameter int ULA_OP = 4
);
    logic [BITS-1:0]   a_in;
    logic [BITS-1:0]   b_in;
    logic [ULA_OP-1:0] ula_op_in;
    logic              flags_we_in;
    logic [BITS-1:0]   result_out;
    logic              zero_out;
    logic              neg_out;
    logic              carry_out;

    modport master (
        output a_in,
        output b_in,
        output ula_op_in,
        output flags_we_in,
        input  result_out,
        input  zero_out,
        input  neg_out,
        input  carry_out
    );

    modport slave (
        input  a_in,
        input  b_in,
        input  ula_op_in,
        input  flags_we_in,
        output result_out,
        output zero_out,
        output neg_out,
        output carry_out
    );
endinterface

// File: rtl/ula_core.sv
// REDUX-V combinational ALU with a clocked zero/negative/carry flag register.
// Result is purely combinational; only the flags use the clock and reset.
module ula_core #(
    parameter int BITS   = 8,
    parameter int ULA_OP = 4
) (
    input  logic        clk_in,
    input  logic        rst_n_in,
    ula_core_if.slave   bus
);

    localparam logic [ULA_OP-1:0] OP_ADD   = ULA_OP'(0);
    localparam logic [ULA_OP-1:0] OP_SUB   = ULA_OP'(1);
    localparam logic [ULA_OP-1:0] OP_AND   = ULA_OP'(2);
    localparam logic [ULA_OP-1:0] OP_OR    = ULA_OP'(3);
    localparam logic [ULA_OP-1:0] OP_XOR   = ULA_OP'(4);
    localparam logic [ULA_OP-1:0] OP_NOT   = ULA_OP'(5);
    localparam logic [ULA_OP-1:0] OP_SHL   = ULA_OP'(6);
    localparam logic [ULA_OP-1:0] OP_SHR   = ULA_OP'(7);
    localparam logic [ULA_OP-1:0] OP_SRA   = ULA_OP'(8);
    localparam logic [ULA_OP-1:0] OP_PASSB = ULA_OP'(9);
    localparam logic [ULA_OP-1:0] OP_SLT   = ULA_OP'(10);
    localparam logic [ULA_OP-1:0] OP_SLTU  = ULA_OP'(11);

    // BITS always fits in BITS bits because BITS >= 2.
    localparam logic [BITS-1:0] WIDTH_V = BITS'(BITS);

    logic [BITS-1:0] a;
    logic [BITS-1:0] b;
    logic [BITS:0]   sum;
    logic            shamt_big;
    logic [BITS-1:0] res;
    logic            zero_d;
    logic            neg_d;
    logic            carry_d;
    logic            zero_q;
    logic            neg_q;
    logic            carry_q;

    assign a = bus.a_in;
    assign b = bus.b_in;

    always_comb begin
        sum       = {1'b0, a} + {1'b0, b};
        shamt_big = (b >= WIDTH_V);
        res       = '0;
        carry_d   = 1'b0;
        case (bus.ula_op_in)
            OP_ADD: begin
                res     = sum[BITS-1:0];
                carry_d = sum[BITS];
            end
            OP_SUB: begin
                res     = a - b;
                carry_d = (a < b);
            end
            OP_AND:   res = a & b;
            OP_OR:    res = a | b;
            OP_XOR:   res = a ^ b;
            OP_NOT:   res = ~a;
            OP_SHL:   res = shamt_big ? '0 : (a << b);
            OP_SHR:   res = shamt_big ? '0 : (a >> b);
            OP_SRA: begin
                if (shamt_big)
                    res = {BITS{a[BITS-1]}};
                else
                    res = BITS'($signed(a) >>> b);
            end
            OP_PASSB: res = b;
            OP_SLT:   res = {{(BITS-1){1'b0}}, ($signed(a) < $signed(b))};
            OP_SLTU:  res = {{(BITS-1){1'b0}}, (a < b)};
            default:  res = '0;
        endcase
        zero_d = (res == '0);
        neg_d  = res[BITS-1];
    end

    always_ff @(posedge clk_in or negedge rst_n_in) begin
        if (!rst_n_in) begin
            zero_q  <= 1'b0;
            neg_q   <= 1'b0;
            carry_q <= 1'b0;
        end else if (bus.flags_we_in) begin
            zero_q  <= zero_d;
            neg_q   <= neg_d;
            carry_q <= carry_d;
        end
    end

    assign bus.result_out = res;
    assign bus.zero_out   = zero_q;
    assign bus.neg_out    = neg_q;
    assign bus.carry_out  = carry_q;

endmodule

// File: tb/tb_ula_core.sv
// Self-checking bench for ula_core at BITS=8 against an arithmetic model.
// Covers directed cases, exhaustive SHL, flag hold/reset and random ops.
module tb_ula_core;

    logic clk;
    logic rst_n;
    int   passed;
    int   total;
    logic exp_z;
    logic exp_n;
    logic exp_c;

    ula_core_if #(.BITS(8), .ULA_OP(4)) bus ();

    ula_core #(.BITS(8), .ULA_OP(4)) dut (
        .clk_in   (clk),
        .rst_n_in (rst_n),
        .bus      (bus)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    function automatic int sgn8(int v);
        return (v >= 128) ? v - 256 : v;
    endfunction

    function automatic logic [7:0] ref_res(int a, int b, int op);
        int sa;
        int sb;
        int p;
        int r;
        sa = sgn8(a);
        sb = sgn8(b);
        p  = (b < 8) ? (1 << b) : 1;
        case (op)
            0:  r = a + b;
            1:  r = a - b;
            2:  r = a & b;
            3:  r = a | b;
            4:  r = a ^ b;
            5:  r = 255 - a;
            6:  r = (b >= 8) ? 0 : a * p;
            7:  r = (b >= 8) ? 0 : a / p;
            8: begin
                if (b >= 8)
                    r = (sa < 0) ? -1 : 0;
                else if (sa < 0)
                    r = -(((-sa) + p - 1) / p);
                else
                    r = sa / p;
            end
            9:  r = b;
            10: r = (sa < sb) ? 1 : 0;
            11: r = (a < b) ? 1 : 0;
            default: r = 0;
        endcase
        return r[7:0];
    endfunction

    function automatic logic ref_carry(int a, int b, int op);
        if (op == 0) return (a + b) > 255;
        if (op == 1) return a < b;
        return 1'b0;
    endfunction

    task automatic drive(int a, int b, int op, logic we);
        bus.a_in        = 8'(a);
        bus.b_in        = 8'(b);
        bus.ula_op_in   = 4'(op);
        bus.flags_we_in = we;
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        drive(8'hFF, 8'h01, 0, 1'b1);
        repeat (2) @(posedge clk);
        #1;
        total++;
        if ({bus.zero_out, bus.neg_out, bus.carry_out} !== 3'b000)
            $display("FAIL reset_flags got %b want 000",
                     {bus.zero_out, bus.neg_out, bus.carry_out});
        else passed++;
        total++;
        if (bus.result_out !== 8'h00)
            $display("FAIL reset_result got %h want 00", bus.result_out);
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 1'b0);
    endtask

    task automatic test_shl_exhaustive();
        logic [7:0] e;
        int errs;
        errs = 0;
        for (int a = 0; a < 256; a++) begin
            for (int b = 0; b < 256; b++) begin
                drive(a, b, 6, 1'b0);
                #1;
                e = ref_res(a, b, 6);
                total++;
                if (bus.result_out !== e) begin
                    if (errs < 10)
                        $display("FAIL shl a=%h b=%h got %h want %h",
                                 a, b, bus.result_out, e);
                    errs++;
                end else passed++;
            end
        end
    endtask

    task automatic test_arith_flags();
        @(posedge clk);
        #1;
        drive(8'hFF, 8'h01, 0, 1'b1);
        #1;
        total++;
        if (bus.result_out !== 8'h00)
            $display("FAIL add_res got %h want 00", bus.result_out);
        else passed++;
        @(posedge clk);
        #1;
        total++;
        if ({bus.zero_out, bus.neg_out, bus.carry_out} !== 3'b101)
            $display("FAIL add_flags got %b want 101",
                     {bus.zero_out, bus.neg_out, bus.carry_out});
        else passed++;
        drive(8'h03, 8'h05, 1, 1'b1);
        #1;
        total++;
        if (bus.result_out !== 8'hFE)
            $display("FAIL sub_res got %h want fe", bus.result_out);
        else passed++;
        @(posedge clk);
        #1;
        total++;
        if ({bus.zero_out, bus.neg_out, bus.carry_out} !== 3'b011)
            $display("FAIL sub_flags got %b want 011",
                     {bus.zero_out, bus.neg_out, bus.carry_out});
        else passed++;
    endtask

    task automatic test_directed();
        int vec [15][4] = '{
            '{8'h80, 3, 7, 8'h10},
            '{8'h80, 3, 8, 8'hF0},
            '{8'h80, 9, 8, 8'hFF},
            '{8'h80, 9, 7, 8'h00},
            '{8'h81, 1, 6, 8'h02},
            '{8'hFF, 7, 6, 8'h80},
            '{8'h5A, 0, 8, 8'h5A},
            '{8'hF0, 8'h3C, 2, 8'h30},
            '{8'hF0, 8'h3C, 3, 8'hFC},
            '{8'hF0, 8'h3C, 4, 8'hCC},
            '{8'hF0, 8'h3C, 5, 8'h0F},
            '{8'hF0, 8'h3C, 9, 8'h3C},
            '{8'hFF, 8'h01, 10, 8'h01},
            '{8'hFF, 8'h01, 11, 8'h00},
            '{8'hF0, 8'h3C, 15, 8'h00}
        };
        for (int i = 0; i < 15; i++) begin
            drive(vec[i][0], vec[i][1], vec[i][2], 1'b0);
            #1;
            total++;
            if (bus.result_out !== 8'(vec[i][3]))
                $display("FAIL directed[%0d] op=%0d got %h want %h",
                         i, vec[i][2], bus.result_out, 8'(vec[i][3]));
            else passed++;
        end
    endtask

    task automatic test_flag_hold();
        logic [7:0] e;
        int a;
        int b;
        int op;
        @(posedge clk);
        #1;
        drive(8'h03, 8'h05, 1, 1'b1);
        @(posedge clk);
        #1;
        for (int i = 0; i < 6; i++) begin
            a  = $urandom_range(0, 255);
            b  = $urandom_range(0, 255);
            op = $urandom_range(0, 15);
            drive(a, b, op, 1'b0);
            #1;
            e = ref_res(a, b, op);
            total++;
            if (bus.result_out !== e)
                $display("FAIL hold_res got %h want %h", bus.result_out, e);
            else passed++;
            @(posedge clk);
            #1;
            total++;
            if ({bus.zero_out, bus.neg_out, bus.carry_out} !== 3'b011)
                $display("FAIL hold_flags got %b want 011",
                         {bus.zero_out, bus.neg_out, bus.carry_out});
            else passed++;
        end
    endtask

    task automatic test_reset_mid_cycle();
        drive(8'h03, 8'h05, 1, 1'b1);
        @(posedge clk);
        #2;
        rst_n = 1'b0;
        #1;
        total++;
        if ({bus.zero_out, bus.neg_out, bus.carry_out} !== 3'b000)
            $display("FAIL midrst_flags got %b want 000",
                     {bus.zero_out, bus.neg_out, bus.carry_out});
        else passed++;
        drive(8'h12, 8'h34, 0, 1'b1);
        #1;
        total++;
        if (bus.result_out !== 8'h46)
            $display("FAIL midrst_res got %h want 46", bus.result_out);
        else passed++;
        drive(8'hFF, 8'h01, 0, 1'b1);
        @(posedge clk);
        #1;
        total++;
        if ({bus.zero_out, bus.neg_out, bus.carry_out} !== 3'b000)
            $display("FAIL rst_wins got %b want 000",
                     {bus.zero_out, bus.neg_out, bus.carry_out});
        else passed++;
        @(negedge clk);
        rst_n = 1'b1;
        drive(0, 0, 0, 1'b0);
    endtask

    task automatic test_random();
        logic [7:0] e;
        int a;
        int b;
        int op;
        logic we;
        @(posedge clk);
        #1;
        drive(0, 0, 0, 1'b1);
        exp_z = 1'b1;
        exp_n = 1'b0;
        exp_c = 1'b0;
        @(posedge clk);
        #1;
        for (int i = 0; i < 400; i++) begin
            a  = $urandom_range(0, 255);
            b  = ($urandom_range(0, 1) == 1) ? $urandom_range(0, 10)
                                             : $urandom_range(0, 255);
            op = $urandom_range(0, 15);
            we = 1'($urandom_range(0, 1));
            drive(a, b, op, we);
            #1;
            e = ref_res(a, b, op);
            total++;
            if (bus.result_out !== e)
                $display("FAIL rand_res a=%h b=%h op=%0d got %h want %h",
                         a, b, op, bus.result_out, e);
            else passed++;
            if (we) begin
                exp_z = (e == 8'h00);
                exp_n = e[7];
                exp_c = ref_carry(a, b, op);
            end
            @(posedge clk);
            #1;
            total++;
            if ({bus.zero_out, bus.neg_out, bus.carry_out} !==
                {exp_z, exp_n, exp_c})
                $display("FAIL rand_flags op=%0d got %b want %b", op,
                         {bus.zero_out, bus.neg_out, bus.carry_out},
                         {exp_z, exp_n, exp_c});
            else passed++;
        end
    endtask

    initial begin
        passed = 0;
        total  = 0;
        test_reset();
        test_shl_exhaustive();
        test_arith_flags();
        test_directed();
        test_flag_hold();
        test_reset_mid_cycle();
        test_random();
        $display("%0d/%0d checks passed", passed, total);
        $finish;
    end

endmodule

// File: doc/ula_core.md
# ula_core

Combinational arithmetic/logic unit for the REDUX-V datapath. It takes two BITS-wide operands and an opcode and produces the result in the same cycle. A small clocked flag register captures zero, negative and carry status of the current operation when enabled. The block sits between the register-file read ports and the write-back mux.

## Interface
Parameters:
- BITS, 8, operand/result width (≥ 2)
- ULA_OP, 4, opcode width (≥ 4)

Ports:
- clk_in  input  1  clock; only the flag register uses it
- rst_n_in  input  1  asynchronous, active-low reset
- a_in  input  BITS  operand A
- b_in  input  BITS  operand B (also the shift amount)
- ula_op_in  input  ULA_OP  operation select
- flags_we_in  input  1  capture flags on the next rising edge
- result_out  output  BITS  combinational result
- zero_out  output  1  registered: last captured result was 0
- neg_out  output  1  registered: MSB of last captured result
- carry_out  output  1  registered: carry/borrow of last captured add/sub

## Operation
- One clock, clk_in. Reset is asynchronous and active-low on rst_n_in.
- result_out depends only on a_in, b_in and ula_op_in. It has no state and is never affected by reset.
- All arithmetic is modulo 2^BITS and unsigned unless stated otherwise.
- Opcode map:
  - 0 ADD: a+b
  - 1 SUB: a−b
  - 2 AND: a&b
  - 3 OR: a|b
  - 4 XOR: a^b
  - 5 NOT: ~a
  - 6 SHL: a << b, logical, zero fill
  - 7 SHR: a >> b, logical, zero fill
  - 8 SRA: a >>> b, arithmetic; fills with a[BITS-1]
  - 9 PASSB: b
  - 10 SLT: 1 if $signed(a) < $signed(b), else 0, zero-extended
  - 11 SLTU: same as SLT, unsigned compare
  - all other codes: result 0
- Shift amount is the full unsigned value of b_in; it is not truncated to log2(BITS) bits.
  - SHL/SHR with b ≥ BITS give 0.
  - SRA with b ≥ BITS gives all copies of a[BITS-1].
  - b = 0 gives a unchanged.
- Carry rules:
  - ADD: carry is bit BITS of the (BITS+1)-bit sum.
  - SUB: carry is 1 when a < b unsigned (borrow).
  - All other opcodes: carry is 0.
- Flag register:
  - On a rising clk_in edge with flags_we_in=1, it loads zero = (result==0), neg = result[BITS-1], and the carry computed from the current inputs.
  - With flags_we_in=0 it holds.

## Timing
- result_out: zero-cycle latency. It settles within one combinational path after any input change and must be valid before the next clk_in edge.
- Flags: one-cycle latency. They reflect the inputs present at the capturing edge.
- Reset: rst_n_in low clears zero_out, neg_out and carry_out to 0 immediately, regardless of clk_in. Release is synchronised by the surrounding reset logic.
- Reset during an enabled edge: reset wins and the flags stay 0.
- No handshake; the block accepts a new operation every cycle.

## Test plan
- SHL exhaustive at BITS=8: for every a,b in 0..255, result = (a<<b) mod 256. Examples: a=0x81,b=1 -> 0x02; a=0xFF,b=7 -> 0x80; any a with b ≥ 8 (e.g. b=200) -> 0x00; b=0 -> a.
- ADD/SUB carry: a=0xFF,b=0x01,ADD,flags_we_in=1 -> result 0x00; after the edge zero=1, carry=1. a=0x03,b=0x05,SUB -> result 0xFE; after the edge neg=1, carry=1.
- Shifts right: a=0x80,b=3, SHR -> 0x10 and SRA -> 0xF0. a=0x80,b=9, SRA -> 0xFF and SHR -> 0x00.
- Logic and compare:
  - a=0xF0,b=0x3C: AND -> 0x30, OR -> 0xFC, XOR -> 0xCC, NOT -> 0x0F, PASSB -> 0x3C.
  - a=0xFF,b=0x01: SLT -> 0x01, SLTU -> 0x00.
  - Unused opcode 15 -> 0x00.
- Flag hold and reset:
  - Set the flags non-zero, then flags_we_in=0 with changing inputs -> flags unchanged.
  - Assert rst_n_in mid-cycle -> all flags 0 immediately, while result_out keeps tracking its inputs.
